// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    localparam logic [31:0] BAUD_DEFAULT_RATE = 32'd115200;

    // Width of a counter that must be able to hold ack_timeout itself.
    function automatic int tmo_cnt_width(input int ack_timeout);
        return $clog2(ack_timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, with wrap-around.
// Zero latency; no state, no backpressure.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte streams, with packet locking.
// One byte per frame; REQ_READYo pulses the cycle after acceptance; baud changes land only between frames.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int          NUM_REQ      = 4,
    parameter int          DATA_WDTH    = 8,
    parameter logic [31:0] BAUD_DEFAULT = BAUD_DEFAULT_RATE,
    parameter int          ACK_TIMEOUT  = 16
) (
    input  logic                           CLKip,
    input  logic                           RSTi,
    input  logic [NUM_REQ*DATA_WDTH-1:0]   REQ_DATAi,
    input  logic [NUM_REQ-1:0]             REQ_VALIDi,
    input  logic [NUM_REQ-1:0]             REQ_LASTi,
    output logic [NUM_REQ-1:0]             REQ_READYo,
    output logic [NUM_REQ-1:0]             GRANTo,
    output logic [DATA_WDTH-1:0]           TX_DATAo,
    output logic                           TX_ENo,
    input  logic                           TX_BUSYi,
    input  logic [31:0]                    BAUD_CFGi,
    input  logic                           BAUD_WEi,
    output logic [31:0]                    BAUD_RATEo,
    output logic                           ACTIVEo,
    output logic                           ERRo,
    input  logic                           ERR_CLRi
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = tmo_cnt_width(ACK_TIMEOUT);

    sched_state_t     state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic             lock;
    logic             baud_pend;
    logic [31:0]      baud_pend_val;
    logic [CNT_W-1:0] tmo_cnt;

    logic [NUM_REQ-1:0] arb_req, arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic baud_apply, accept, launch_ack, launch_tmo, frame_done;

    // While locked, the current owner's grant masks out every other requester.
    assign arb_req = lock ? (REQ_VALIDi & GRANTo) : REQ_VALIDi;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign baud_apply = (state == IDLE) && !TX_BUSYi && (baud_pend || BAUD_WEi);
    assign accept     = (state == IDLE) && !TX_BUSYi && !baud_apply && arb_any;
    assign launch_ack = (state == LAUNCH) && TX_BUSYi;
    assign launch_tmo = (state == LAUNCH) && !TX_BUSYi && (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign frame_done = (state == WAIT_DONE) && !TX_BUSYi;

    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = LAUNCH;
            LAUNCH:    if (launch_ack) state_nxt = WAIT_DONE;
                       else if (launch_tmo) state_nxt = IDLE;
            WAIT_DONE: if (frame_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ACTIVEo = (state == LAUNCH) || (state == WAIT_DONE);
    end

    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            REQ_READYo    <= '0;
            GRANTo        <= '0;
            TX_DATAo      <= '0;
            TX_ENo        <= 1'b0;
            ERRo          <= 1'b0;
            BAUD_RATEo    <= BAUD_DEFAULT;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            lock          <= 1'b0;
            baud_pend     <= 1'b0;
            baud_pend_val <= '0;
            tmo_cnt       <= '0;
        end else begin
            REQ_READYo <= accept ? arb_gnt : '0;

            if (accept) begin
                TX_DATAo <= REQ_DATAi[int'(arb_idx)*DATA_WDTH +: DATA_WDTH];
                GRANTo   <= arb_gnt;
                rr_ptr   <= arb_idx;
                lock     <= !REQ_LASTi[arb_idx];
                TX_ENo   <= 1'b1;
                tmo_cnt  <= '0;
            end

            if (state == LAUNCH) begin
                if (launch_ack) begin
                    TX_ENo <= 1'b0;
                end else if (launch_tmo) begin
                    TX_ENo <= 1'b0;
                    lock   <= 1'b0;
                    GRANTo <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            if (frame_done && !lock) GRANTo <= '0;

            if (launch_tmo)    ERRo <= 1'b1;
            else if (ERR_CLRi) ERRo <= 1'b0;

            // A write arriving in the apply cycle supersedes the older pending value.
            if (baud_apply) begin
                BAUD_RATEo <= BAUD_WEi ? BAUD_CFGi : baud_pend_val;
                baud_pend  <= 1'b0;
            end else if (BAUD_WEi) begin
                baud_pend     <= 1'b1;
                baud_pend_val <= BAUD_CFGi;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural uart_tx handshake responder.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int FRAME = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  req_valid, req_last, req_ready, grant;
    logic [W-1:0]  tx_data;
    logic          tx_en, tx_busy;
    logic [31:0]   baud_cfg, baud_rate;
    logic          baud_we, active, err, err_clr;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  rst_events = 0;
    bit  uart_dead = 1'b0;

    logic [8:0] byte_q[N][$];
    int         acc_idx[$];
    int         acc_cyc[$];
    logic [7:0] acc_dat[$];
    logic [N-1:0] prev_ready = '0;

    logic [7:0] cap;
    int         snap;
    int         en_cycles;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .DATA_WDTH(W), .BAUD_DEFAULT(32'd115200), .ACK_TIMEOUT(16)) dut (
        .CLKip      (clk),
        .RSTi       (rst),
        .REQ_DATAi  (req_data),
        .REQ_VALIDi (req_valid),
        .REQ_LASTi  (req_last),
        .REQ_READYo (req_ready),
        .GRANTo     (grant),
        .TX_DATAo   (tx_data),
        .TX_ENo     (tx_en),
        .TX_BUSYi   (tx_busy),
        .BAUD_CFGi  (baud_cfg),
        .BAUD_WEi   (baud_we),
        .BAUD_RATEo (baud_rate),
        .ACTIVEo    (active),
        .ERRo       (err),
        .ERR_CLRi   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int budget = 200;
        while (acc_idx.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, 32'(acc_idx.size() >= n), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        int budget = 50;
        while (!tx_busy && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, 32'(tx_busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int budget = 100;
        while ((active || tx_busy) && budget > 0) begin
            tick();
            budget--;
        end
        chk(tag, 32'(active || tx_busy), 32'd0);
    endtask

    task automatic chk_acc(input string pfx, input int i, input int idx, input logic [7:0] dat);
        chk($sformatf("%s_idx%0d", pfx, i), 32'(acc_idx[i]), 32'(idx));
        chk($sformatf("%s_dat%0d", pfx, i), 32'(acc_dat[i]), 32'(dat));
    endtask

    task automatic clear_acc();
        acc_idx.delete();
        acc_cyc.delete();
        acc_dat.delete();
    endtask

    // Requesters: present the queue head, pop it when the accept pulse is seen.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (req_ready[k] && byte_q[k].size() > 0) void'(byte_q[k].pop_front());
                req_valid[k] = byte_q[k].size() > 0;
                if (byte_q[k].size() > 0) begin
                    req_data[k*W +: W] = byte_q[k][0][7:0];
                    req_last[k]        = byte_q[k][0][8];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_ready != '0) chk("ready_pulse", 32'(req_ready), 32'd0);
            if (req_ready != '0) begin
                acc_idx.push_back($clog2(req_ready));
                acc_dat.push_back(tx_data);
                acc_cyc.push_back(cyc);
            end
            prev_ready = req_ready;
        end
    end

    // uart_tx stand-in: BUSY rises one cycle after TX_EN, holds for FRAME cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_en && !uart_dead) begin
                @(posedge clk);
                #1;
                tx_busy = 1'b1;
                cap  = tx_data;
                snap = rst_events;
                @(posedge clk);
                #1;
                chk("en_drop", 32'(tx_en), 32'd0);
                repeat (FRAME - 1) begin
                    @(posedge clk);
                    #1;
                end
                if (snap == rst_events) chk("data_stable", 32'(tx_data), 32'(cap));
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        baud_we  = 1'b0;
        baud_cfg = '0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready",  32'(req_ready), 32'd0);
        chk("rst_grant",  32'(grant),     32'd0);
        chk("rst_data",   32'(tx_data),   32'd0);
        chk("rst_en",     32'(tx_en),     32'd0);
        chk("rst_active", 32'(active),    32'd0);
        chk("rst_err",    32'(err),       32'd0);
        chk("rst_baud",   baud_rate,      32'd115200);
        rst = 1'b0;
        tick();

        // Round robin from the reset pointer: 0,1,2,0,1,2 at one byte per 9-cycle frame.
        clear_acc();
        byte_q[0].push_back({1'b1, 8'h10}); byte_q[0].push_back({1'b1, 8'h11});
        byte_q[1].push_back({1'b1, 8'h20}); byte_q[1].push_back({1'b1, 8'h21});
        byte_q[2].push_back({1'b1, 8'h30}); byte_q[2].push_back({1'b1, 8'h31});
        wait_acc(6, "rr_wait");
        chk_acc("rr", 0, 0, 8'h10);
        chk_acc("rr", 1, 1, 8'h20);
        chk_acc("rr", 2, 2, 8'h30);
        chk_acc("rr", 3, 0, 8'h11);
        chk_acc("rr", 4, 1, 8'h21);
        chk_acc("rr", 5, 2, 8'h31);
        chk("rr_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
        wait_idle("rr_idle");

        clear_acc();
        byte_q[0].push_back({1'b1, 8'hA5});
        wait_acc(1, "single_wait");
        chk_acc("single", 0, 0, 8'hA5);
        chk("single_grant",  32'(grant),  32'h1);
        chk("single_en",     32'(tx_en),  32'd1);
        chk("single_active", 32'(active), 32'd1);
        wait_idle("single_idle");
        chk("single_grant_clr", 32'(grant), 32'd0);

        // Locked packet from requester 1 must not be interleaved with requester 0.
        clear_acc();
        byte_q[1].push_back({1'b0, 8'h1A});
        byte_q[1].push_back({1'b0, 8'h1B});
        byte_q[1].push_back({1'b1, 8'h1C});
        byte_q[0].push_back({1'b1, 8'h0E});
        wait_acc(1, "lock_wait1");
        begin
            int budget = 40;
            while (acc_idx.size() < 3 && budget > 0) begin
                chk("lock_grant", 32'(grant), 32'h2);
                tick();
                budget--;
            end
        end
        wait_acc(4, "lock_wait4");
        chk_acc("lock", 0, 1, 8'h1A);
        chk_acc("lock", 1, 1, 8'h1B);
        chk_acc("lock", 2, 1, 8'h1C);
        chk_acc("lock", 3, 0, 8'h0E);
        chk("lock_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);
        wait_idle("lock_idle");
        chk("lock_grant_clr", 32'(grant), 32'd0);

        uart_dead = 1'b1;
        clear_acc();
        byte_q[2].push_back({1'b1, 8'h2A});
        byte_q[3].push_back({1'b1, 8'h3B});
        wait_acc(1, "tmo_wait");
        chk_acc("tmo", 0, 2, 8'h2A);
        en_cycles = 0;
        begin
            int budget = 40;
            while (tx_en && budget > 0) begin
                en_cycles++;
                tick();
                budget--;
            end
        end
        uart_dead = 1'b0;
        chk("tmo_en_cycles", 32'(en_cycles), 32'd16);
        chk("tmo_err",       32'(err),       32'd1);
        chk("tmo_grant",     32'(grant),     32'd0);
        chk("tmo_active",    32'(active),    32'd0);
        wait_acc(2, "tmo_next_wait");
        chk_acc("tmo", 1, 3, 8'h3B);
        chk("tmo_err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_err_clr", 32'(err), 32'd0);
        wait_idle("tmo_idle");

        // Baud write mid-frame waits for the frame end and costs one idle cycle.
        clear_acc();
        byte_q[0].push_back({1'b1, 8'h55});
        byte_q[1].push_back({1'b1, 8'h66});
        wait_acc(1, "baud_wait1");
        wait_busy("baud_busy");
        baud_cfg = 32'd9600;
        baud_we  = 1'b1;
        tick();
        baud_we  = 1'b0;
        chk("baud_hold", baud_rate, 32'd115200);
        wait_acc(2, "baud_wait2");
        chk("baud_new", baud_rate, 32'd9600);
        chk_acc("baud", 1, 1, 8'h66);
        chk("baud_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
        wait_idle("baud_idle");

        clear_acc();
        byte_q[1].push_back({1'b1, 8'h71});
        wait_acc(1, "rstm_wait");
        chk_acc("rstm", 0, 1, 8'h71);
        wait_busy("rstm_busy");
        tick();
        chk("rstm_active_pre", 32'(active), 32'd1);
        rst_events++;
        rst = 1'b1;
        #1;
        chk("rstm_grant",  32'(grant),     32'd0);
        chk("rstm_data",   32'(tx_data),   32'd0);
        chk("rstm_en",     32'(tx_en),     32'd0);
        chk("rstm_active", 32'(active),    32'd0);
        chk("rstm_ready",  32'(req_ready), 32'd0);
        chk("rstm_baud",   baud_rate,      32'd115200);
        tick();
        tick();
        clear_acc();
        byte_q[0].push_back({1'b1, 8'h01});
        byte_q[3].push_back({1'b1, 8'h03});
        rst = 1'b0;
        wait_acc(2, "rstm_post_wait");
        chk_acc("rstm_post", 0, 0, 8'h01);
        chk_acc("rstm_post", 1, 3, 8'h03);
        wait_idle("rstm_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
